multicycle_control_fsm: RTL and testbench

Multicycle sequencer for the MIPS datapath: replaces single-cycle decode with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback over 3-5 cycles, sharing one ULA and one unified instruction/data memory. It sits between the instruction register (OP and Funct fields) and the datapath multiplexers and write enables, and stalls on a memory ready handshake. Supported set: add, sub, and, or, slt, lw, sw, beq, addi, andi, ori, j.

---
 rtl/multicycle_control_fsm.sv | 278 +++++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Moore sequencer for a multicycle MIPS datapath. Each instruction moves
// through fetch, decode, execute, memory and writeback in 3-5 cycles. One ULA
// and one unified instruction/data memory are shared across those cycles.
// Memory accesses stall on mem_ready.
//
// Supported instructions: add, sub, and, or, slt, lw, sw, beq, addi, andi,
// ori, j. Any other OP/Funct raises illegal_op in DECODE and the sequencer
// returns to FETCH without retiring anything.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   OP, Funct    opcode / funct fields from the instruction register
//   mem_ready    memory completes the current access this cycle
//   mem_req      memory access requested
//   IorD         address source: 0 = PC, 1 = ULAOut register
//   MemWrite, IRWrite, PCWrite, Branch, RegWrite, RegDst, MemtoReg, ULASrcA
//                datapath write enables / mux selects
//   ULASrcB      00 reg B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm << 2
//   PCSrc        00 ULA result, 01 ULAOut register, 10 jump target
//   ULAControl   010 add, 110 sub, 000 and, 001 or, 111 slt
//   done         one-cycle pulse on the final cycle of each instruction
//   illegal_op   one-cycle pulse in DECODE for an unsupported OP/Funct
//   state        current state encoding
// ---------------------------------------------------------------------------
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ULASrcA,
    output logic [1:0] ULASrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ULAControl,
    output logic       done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMM_EX = 4'd9,
        S_IMM_WB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_SLT = 3'b111;

    // Supported R-type funct codes, packed so a generate loop can match them.
    localparam int         N_FUNCT  = 5;
    localparam logic [29:0] R_FUNCTS = {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

    state_t state_reg;
    state_t state_next;

    logic [N_FUNCT-1:0] funct_hit;
    logic               op_mem;
    logic               op_r_legal;
    logic               op_beq;
    logic               op_imm;
    logic               op_j;
    logic               op_legal;
    logic [2:0]         r_ula_ctl;
    logic [2:0]         imm_ula_ctl;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_FUNCT; gi++) begin : g_funct_match
            assign funct_hit[gi] = (Funct == R_FUNCTS[gi*6 +: 6]);
        end
    endgenerate

    assign op_mem     = (OP == OP_LW) || (OP == OP_SW);
    assign op_r_legal = (OP == OP_RTYPE) && (|funct_hit);
    assign op_beq     = (OP == OP_BEQ);
    assign op_imm     = (OP == OP_ADDI) || (OP == OP_ANDI) || (OP == OP_ORI);
    assign op_j       = (OP == OP_J);
    assign op_legal   = op_mem || op_r_legal || op_beq || op_imm || op_j;

    always_comb begin
        r_ula_ctl = ULA_ADD;
        case (Funct)
            FN_ADD:  r_ula_ctl = ULA_ADD;
            FN_SUB:  r_ula_ctl = ULA_SUB;
            FN_AND:  r_ula_ctl = ULA_AND;
            FN_OR:   r_ula_ctl = ULA_OR;
            FN_SLT:  r_ula_ctl = ULA_SLT;
            default: r_ula_ctl = ULA_ADD;
        endcase
    end

    always_comb begin
        imm_ula_ctl = ULA_ADD;
        case (OP)
            OP_ANDI: imm_ula_ctl = ULA_AND;
            OP_ORI:  imm_ula_ctl = ULA_OR;
            default: imm_ula_ctl = ULA_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_FETCH:  state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (op_mem)          state_next = S_MEMADR;
                else if (op_r_legal) state_next = S_EXEC_R;
                else if (op_beq)     state_next = S_BRANCH;
                else if (op_imm)     state_next = S_IMM_EX;
                else if (op_j)       state_next = S_JUMP;
                else                 state_next = S_FETCH;
            end
            S_MEMADR: state_next = (OP == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_next = S_FETCH;
            S_MEMWR:  state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC_R: state_next = S_ALUWB;
            S_ALUWB:  state_next = S_FETCH;
            S_BRANCH: state_next = S_FETCH;
            S_IMM_EX: state_next = S_IMM_WB;
            S_IMM_WB: state_next = S_FETCH;
            S_JUMP:   state_next = S_FETCH;
            default:  state_next = S_FETCH;   // unused codes 12-15 recover
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the state register. mem_ready only qualifies
    // the one-shot enables of the memory states, so a stalled access keeps
    // mem_req high without repeating its writes. Everything is gated by
    // rst_n so reset silences the datapath without waiting for a clock.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ULASrcA    = 1'b0;
        ULASrcB    = 2'b00;
        PCSrc      = 2'b00;
        ULAControl = 3'b000;
        done       = 1'b0;
        illegal_op = 1'b0;
        state      = 4'd0;
        if (rst_n) begin
            state = state_reg;
            case (state_reg)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ULASrcB    = 2'b01;
                    ULAControl = ULA_ADD;
                    IRWrite    = mem_ready;
                    PCWrite    = mem_ready;
                end
                S_DECODE: begin
                    // Branch target is precomputed here while OP is decoded.
                    ULASrcB    = 2'b11;
                    ULAControl = ULA_ADD;
                    illegal_op = !op_legal;
                end
                S_MEMADR: begin
                    ULASrcA    = 1'b1;
                    ULASrcB    = 2'b10;
                    ULAControl = ULA_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    done     = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = mem_ready;
                    done     = mem_ready;
                end
                S_EXEC_R: begin
                    ULASrcA    = 1'b1;
                    ULASrcB    = 2'b00;
                    ULAControl = r_ula_ctl;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    done     = 1'b1;
                end
                S_BRANCH: begin
                    // Datapath ANDs Branch with Zero to decide the PC load.
                    ULASrcA    = 1'b1;
                    ULAControl = ULA_SUB;
                    Branch     = 1'b1;
                    PCSrc      = 2'b01;
                    done       = 1'b1;
                end
                S_IMM_EX: begin
                    ULASrcA    = 1'b1;
                    ULASrcB    = 2'b10;
                    ULAControl = imm_ula_ctl;
                end
                S_IMM_WB: begin
                    RegWrite = 1'b1;
                    done     = 1'b1;
                end
                S_JUMP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 2'b10;
                    done    = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed testbench. A behavioural model builds the expected per-cycle
// output trace of each instruction from its class, fetch wait count and
// memory wait count. It also produces the mem_ready pattern to drive. The
// run task drives that pattern and compares every cycle. Hand-computed
// literals pin trace lengths and key output values.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic       RegWrite, RegDst, MemtoReg, ULASrcA;
    logic [1:0] ULASrcB, PCSrc;
    logic [2:0] ULAControl;
    logic       done, illegal_op;
    logic [3:0] state;

    multicycle_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .OP(OP), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB), .PCSrc(PCSrc),
        .ULAControl(ULAControl), .done(done), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, iord, memwrite, irwrite, pcwrite, branch;
        logic       regwrite, regdst, memtoreg, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] ctl;
        logic       done, illegal;
    } outs_t;

    localparam int K_R = 0, K_LW = 1, K_SW = 2, K_BEQ = 3, K_IMM = 4, K_J = 5, K_ILL = 6;

    outs_t exp_q[$];
    bit    rdy_q[$];
    outs_t obs_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    function automatic outs_t sample();
        outs_t o;
        o.st = state;       o.mem_req = mem_req;   o.iord = IorD;
        o.memwrite = MemWrite; o.irwrite = IRWrite; o.pcwrite = PCWrite;
        o.branch = Branch;  o.regwrite = RegWrite; o.regdst = RegDst;
        o.memtoreg = MemtoReg; o.srca = ULASrcA;   o.srcb = ULASrcB;
        o.pcsrc = PCSrc;    o.ctl = ULAControl;    o.done = done;
        o.illegal = illegal_op;
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int classify(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'd0:  return (f inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42}) ? K_R : K_ILL;
            6'd35: return K_LW;
            6'd43: return K_SW;
            6'd4:  return K_BEQ;
            6'd8, 6'd12, 6'd13: return K_IMM;
            6'd2:  return K_J;
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] alu_code(input logic [5:0] op, input logic [5:0] f);
        if (op == 6'd0) begin
            case (f)
                6'd34: return 3'b110;
                6'd36: return 3'b000;
                6'd37: return 3'b001;
                6'd42: return 3'b111;
                default: return 3'b010;
            endcase
        end
        if (op == 6'd12) return 3'b000;
        if (op == 6'd13) return 3'b001;
        return 3'b010;
    endfunction

    task automatic push(input outs_t o, input bit r);
        exp_q.push_back(o);
        rdy_q.push_back(r);
    endtask

    // One memory access phase: waits with mem_ready low, then the completing cycle.
    task automatic mem_phase(input logic [3:0] st, input int waits, input bit is_write);
        outs_t o;
        for (int i = 0; i < waits; i++) begin
            o = '0; o.st = st; o.mem_req = 1'b1; o.iord = 1'b1;
            push(o, 1'b0);
        end
        o = '0; o.st = st; o.mem_req = 1'b1; o.iord = 1'b1;
        o.memwrite = is_write; o.done = is_write;
        push(o, 1'b1);
    endtask

    task automatic build(input logic [5:0] op, input logic [5:0] f, input int fw, input int mw);
        outs_t o;
        int    k;
        exp_q.delete();
        rdy_q.delete();
        k = classify(op, f);
        for (int i = 0; i < fw; i++) begin
            o = '0; o.st = 4'd0; o.mem_req = 1'b1; o.srcb = 2'b01; o.ctl = 3'b010;
            push(o, 1'b0);
        end
        o = '0; o.st = 4'd0; o.mem_req = 1'b1; o.srcb = 2'b01; o.ctl = 3'b010;
        o.irwrite = 1'b1; o.pcwrite = 1'b1;
        push(o, 1'b1);
        o = '0; o.st = 4'd1; o.srcb = 2'b11; o.ctl = 3'b010; o.illegal = (k == K_ILL);
        push(o, 1'b1);
        case (k)
            K_LW, K_SW: begin
                o = '0; o.st = 4'd2; o.srca = 1'b1; o.srcb = 2'b10; o.ctl = 3'b010;
                push(o, 1'b1);
                if (k == K_LW) begin
                    mem_phase(4'd3, mw, 1'b0);
                    o = '0; o.st = 4'd4; o.regwrite = 1'b1; o.memtoreg = 1'b1; o.done = 1'b1;
                    push(o, 1'b1);
                end else begin
                    mem_phase(4'd5, mw, 1'b1);
                end
            end
            K_R: begin
                o = '0; o.st = 4'd6; o.srca = 1'b1; o.ctl = alu_code(op, f);
                push(o, 1'b1);
                o = '0; o.st = 4'd7; o.regwrite = 1'b1; o.regdst = 1'b1; o.done = 1'b1;
                push(o, 1'b1);
            end
            K_BEQ: begin
                o = '0; o.st = 4'd8; o.srca = 1'b1; o.ctl = 3'b110; o.branch = 1'b1;
                o.pcsrc = 2'b01; o.done = 1'b1;
                push(o, 1'b1);
            end
            K_IMM: begin
                o = '0; o.st = 4'd9; o.srca = 1'b1; o.srcb = 2'b10; o.ctl = alu_code(op, f);
                push(o, 1'b1);
                o = '0; o.st = 4'd10; o.regwrite = 1'b1; o.done = 1'b1;
                push(o, 1'b1);
            end
            K_J: begin
                o = '0; o.st = 4'd11; o.pcwrite = 1'b1; o.pcsrc = 2'b10; o.done = 1'b1;
                push(o, 1'b1);
            end
            default: begin
            end
        endcase
    endtask

    // ---------------- driver + per-cycle compare ----------------
    // Called at a falling edge with the DUT in FETCH. Leaves at a falling
    // edge after the final cycle, unless cut >= 0 stops it mid-instruction.
    task automatic run(input string name, input logic [5:0] op, input logic [5:0] f,
                       input int fw, input int mw, input int exp_len, input int cut);
        outs_t cur;
        int    irw_cnt, done_cnt, done_idx;
        OP = op;
        Funct = f;
        build(op, f, fw, mw);
        obs_q.delete();
        chk({name, " model length"}, exp_q.size(), exp_len);
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready = rdy_q[i];
            #1;
            cur = sample();
            obs_q.push_back(cur);
            n_checks++;
            if (cur !== exp_q[i]) begin
                n_errors++;
                $display("FAIL %s cycle %0d: got %h, expected %h", name, i, cur, exp_q[i]);
            end
            if (i == cut) begin
                $display("tb: %s cut at cycle %0d state %0d", name, i, cur.st);
                return;
            end
            @(negedge clk);
        end
        irw_cnt = 0; done_cnt = 0; done_idx = -1;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].irwrite === 1'b1) irw_cnt++;
            if (obs_q[i].done === 1'b1) begin done_cnt++; done_idx = i; end
        end
        chk({name, " IRWrite count"}, irw_cnt, 1);
        if (classify(op, f) == K_ILL) begin
            chk({name, " done count"}, done_cnt, 0);
        end else begin
            chk({name, " done count"}, done_cnt, 1);
            chk({name, " done cycle"}, done_idx, exp_len - 1);
        end
        $display("tb: %s op=%b funct=%b fetch_wait=%0d mem_wait=%0d cycles=%0d",
                 name, op, f, fw, mw, obs_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int memwrite_cnt;
        logic [3:0] lw_states [7];
        logic [3:0] add_states [4];
        lw_states  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
        add_states = '{4'd0, 4'd1, 4'd6, 4'd7};

        // Reset held low: all outputs must be 0.
        rst_n = 1'b0; mem_ready = 1'b0; OP = 6'd0; Funct = 6'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset outputs", sample(), 0);
        rst_n = 1'b1;
        #1;
        chk("post-reset mem_req", mem_req, 1);
        chk("post-reset state", state, 0);
        $display("tb: reset released, FETCH visible");
        @(negedge clk);

        // add, zero wait
        run("add", 6'b000000, 6'b100000, 0, 0, 4, -1);
        for (int i = 0; i < 4; i++) chk("add state", obs_q[i].st, add_states[i]);
        chk("add EXEC_R ULAControl", obs_q[2].ctl, 3'b010);
        chk("add ALUWB RegWrite/RegDst/done",
            {obs_q[3].regwrite, obs_q[3].regdst, obs_q[3].done}, 3'b111);

        // lw with 2 memory wait cycles
        run("lw", 6'b100011, 6'b000000, 0, 2, 7, -1);
        for (int i = 0; i < 7; i++) chk("lw state", obs_q[i].st, lw_states[i]);
        chk("lw IorD in MEMRD", {obs_q[3].iord, obs_q[4].iord, obs_q[5].iord}, 3'b111);
        chk("lw mem_req in MEMRD", {obs_q[3].mem_req, obs_q[4].mem_req, obs_q[5].mem_req}, 3'b111);

        // sw then beq
        run("sw", 6'b101011, 6'b000000, 0, 0, 4, -1);
        memwrite_cnt = 0;
        foreach (obs_q[i]) if (obs_q[i].memwrite === 1'b1) memwrite_cnt++;
        chk("sw MemWrite count", memwrite_cnt, 1);
        chk("sw MemWrite with IorD", {obs_q[3].memwrite, obs_q[3].iord}, 2'b11);
        run("beq", 6'b000100, 6'b000000, 0, 0, 3, -1);
        chk("beq cycle3 Branch/PCSrc/ULAControl",
            {obs_q[2].branch, obs_q[2].pcsrc, obs_q[2].ctl}, {1'b1, 2'b01, 3'b110});

        // j then ori
        run("j", 6'b000010, 6'b000000, 0, 0, 3, -1);
        chk("j cycle3 PCWrite/PCSrc", {obs_q[2].pcwrite, obs_q[2].pcsrc}, 3'b110);
        run("ori", 6'b001101, 6'b000000, 0, 0, 4, -1);
        chk("ori IMM_EX ULAControl/ULASrcB", {obs_q[2].ctl, obs_q[2].srcb}, 5'b001_10);
        chk("ori IMM_WB RegWrite/RegDst", {obs_q[3].regwrite, obs_q[3].regdst}, 2'b10);

        // illegal opcode and illegal R-type funct
        run("illegal_op", 6'b111111, 6'b000000, 0, 0, 2, -1);
        chk("illegal_op pulse in DECODE", {obs_q[1].st, obs_q[1].illegal}, 5'b0001_1);
        run("illegal_funct", 6'b000000, 6'b000000, 0, 0, 2, -1);
        chk("illegal_funct pulse", obs_q[1].illegal, 1);
        chk("back in FETCH after illegal", state, 0);

        // remaining ALU ops, including fetch and store stalls
        run("sub", 6'b000000, 6'b100010, 2, 0, 6, -1);
        run("and", 6'b000000, 6'b100100, 0, 0, 4, -1);
        run("or",  6'b000000, 6'b100101, 1, 0, 5, -1);
        run("slt", 6'b000000, 6'b101010, 0, 0, 4, -1);
        chk("slt ULAControl", obs_q[2].ctl, 3'b111);
        run("addi", 6'b001000, 6'b000000, 0, 0, 4, -1);
        run("andi", 6'b001100, 6'b000000, 0, 0, 4, -1);
        chk("andi ULAControl", obs_q[2].ctl, 3'b000);
        run("sw_wait", 6'b101011, 6'b000000, 1, 3, 8, -1);

        // Reset pulsed mid EXEC_R: async clear, silent outputs, clean restart.
        run("add_rst", 6'b000000, 6'b100000, 0, 0, 4, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset outputs", sample(), 0);
        @(negedge clk);
        #1;
        chk("reset held after edge", sample(), 0);
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("restart FETCH mem_req/state", {mem_req, state}, 5'b1_0000);
        @(negedge clk);
        run("add_after_rst", 6'b000000, 6'b100000, 0, 0, 4, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
